// File: rtl/mb_scan_ctrl.sv
// Macroblock scan controller: walks a frame in 16x16 macroblocks and
// presents each macroblock's sixteen 4x4 blocks in raster order.
module mb_scan_ctrl #(
    parameter int FRAME_W = 176,
    parameter int FRAME_H = 144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        blk_ready,
    output logic        blk_valid,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [3:0]  blk_idx,
    output logic        mb_last,
    output logic        frame_done,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int MB_COLS = FRAME_W / 16;
    localparam int MB_ROWS = FRAME_H / 16;
    localparam int MBX_W   = (MB_COLS > 1) ? $clog2(MB_COLS) : 1;
    localparam int MBY_W   = (MB_ROWS > 1) ? $clog2(MB_ROWS) : 1;
    localparam logic [MBX_W-1:0] MBX_LAST = MBX_W'(MB_COLS - 1);
    localparam logic [MBY_W-1:0] MBY_LAST = MBY_W'(MB_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [MBX_W-1:0] mb_x;
    logic [MBX_W-1:0] mb_x_next;
    logic [MBY_W-1:0] mb_y;
    logic [MBY_W-1:0] mb_y_next;
    logic [1:0]       sub_x;
    logic [1:0]       sub_x_next;
    logic [1:0]       sub_y;
    logic [1:0]       sub_y_next;

    logic accept;
    logic mb_end;
    logic row_end;
    logic frame_end;

    // Handshake: blk_valid is high for the whole of SCAN and does not depend
    // on blk_ready; a block is consumed on any rising edge where both are
    // high, and the presented coordinate only changes after such an edge.
    assign accept    = (state == SCAN) && blk_ready;
    assign mb_end    = (sub_x == 2'd3) && (sub_y == 2'd3);
    assign row_end   = (mb_x == MBX_LAST);
    assign frame_end = row_end && (mb_y == MBY_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mb_x  <= '0;
            mb_y  <= '0;
            sub_x <= '0;
            sub_y <= '0;
        end else begin
            state <= state_next;
            mb_x  <= mb_x_next;
            mb_y  <= mb_y_next;
            sub_x <= sub_x_next;
            sub_y <= sub_y_next;
        end
    end

    always_comb begin
        state_next = state;
        mb_x_next  = mb_x;
        mb_y_next  = mb_y;
        sub_x_next = sub_x;
        sub_y_next = sub_y;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    mb_x_next  = '0;
                    mb_y_next  = '0;
                    sub_x_next = '0;
                    sub_y_next = '0;
                end
            end
            SCAN: begin
                if (accept) begin
                    if (!mb_end) begin
                        if (sub_x == 2'd3) begin
                            sub_x_next = '0;
                            sub_y_next = sub_y + 1'b1;
                        end else begin
                            sub_x_next = sub_x + 1'b1;
                        end
                    end else begin
                        sub_x_next = '0;
                        sub_y_next = '0;
                        if (!row_end) begin
                            mb_x_next = mb_x + 1'b1;
                        end else begin
                            mb_x_next = '0;
                            if (!frame_end) begin
                                mb_y_next = mb_y + 1'b1;
                            end else begin
                                // Counters are already zero on entry to DONE, so outputs read 0 there.
                                mb_y_next  = '0;
                                state_next = DONE;
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign blk_valid  = (state == SCAN);
    assign frame_done = (state == DONE);
    assign busy       = (state != IDLE);
    assign x          = (32'(mb_x) << 4) + (32'(sub_x) << 2);
    assign y          = (32'(mb_y) << 4) + (32'(sub_y) << 2);
    assign blk_idx    = {sub_y, sub_x};
    assign mb_last    = blk_valid && mb_end;
    assign state_dbg  = state;

endmodule

// File: tb/tb_mb_scan_ctrl.sv
// Bench for mb_scan_ctrl: a 32x16 and a 32x32 instance share stimulus and are
// compared every cycle against a block-count model, plus directed literal checks.
module tb_mb_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        blk_ready;
    logic        valid_o [2];
    logic [31:0] x_o     [2];
    logic [31:0] y_o     [2];
    logic [3:0]  idx_o   [2];
    logic        last_o  [2];
    logic        fd_o    [2];
    logic        busy_o  [2];
    logic [1:0]  st_o    [2];

    int n_checks = 0;
    int n_fail   = 0;

    mb_scan_ctrl #(.FRAME_W(32), .FRAME_H(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .blk_ready(blk_ready),
        .blk_valid(valid_o[0]), .x(x_o[0]), .y(y_o[0]), .blk_idx(idx_o[0]),
        .mb_last(last_o[0]), .frame_done(fd_o[0]), .busy(busy_o[0]),
        .state_dbg(st_o[0])
    );

    mb_scan_ctrl #(.FRAME_W(32), .FRAME_H(32)) dut1 (
        .clk(clk), .rst(rst), .start(start), .blk_ready(blk_ready),
        .blk_valid(valid_o[1]), .x(x_o[1]), .y(y_o[1]), .blk_idx(idx_o[1]),
        .mb_last(last_o[1]), .frame_done(fd_o[1]), .busy(busy_o[1]),
        .state_dbg(st_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: each instance is either idle, scanning with k blocks accepted so
    // far, or in its one-cycle done pulse.
    int k_m   [2] = '{0, 0};
    bit run_m [2] = '{0, 0};
    bit done_m[2] = '{0, 0};
    int tot_m [2] = '{32, 64};
    localparam int COLS = 2;

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                k_m[i] = 0; run_m[i] = 0; done_m[i] = 0;
            end else if (done_m[i]) begin
                done_m[i] = 0;
            end else if (run_m[i]) begin
                if (blk_ready) begin
                    if (k_m[i] == tot_m[i] - 1) begin
                        run_m[i] = 0; done_m[i] = 1; k_m[i] = 0;
                    end else begin
                        k_m[i] = k_m[i] + 1;
                    end
                end
            end else if (start) begin
                run_m[i] = 1; k_m[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int mb, sb, ex, ey, ei, el;
            mb = k_m[i] / 16;
            sb = k_m[i] % 16;
            ex = 0; ey = 0; ei = 0; el = 0;
            if (run_m[i]) begin
                ex = (mb % COLS) * 16 + (sb % 4) * 4;
                ey = (mb / COLS) * 16 + (sb / 4) * 4;
                ei = sb;
                el = (sb == 15) ? 1 : 0;
            end
            check($sformatf("cmp%0d_valid", i), 32'(valid_o[i]), 32'(run_m[i]));
            check($sformatf("cmp%0d_x", i), x_o[i], 32'(ex));
            check($sformatf("cmp%0d_y", i), y_o[i], 32'(ey));
            check($sformatf("cmp%0d_idx", i), 32'(idx_o[i]), 32'(ei));
            check($sformatf("cmp%0d_last", i), 32'(last_o[i]), 32'(el));
            check($sformatf("cmp%0d_done", i), 32'(fd_o[i]), 32'(done_m[i]));
            check($sformatf("cmp%0d_busy", i), 32'(busy_o[i]), 32'(run_m[i] | done_m[i]));
        end
    end

    task automatic wait_done0();
        for (int n = 0; n < 200; n++) begin
            if (fd_o[0]) break;
            tick();
        end
        check("wait_frame_done", 32'(fd_o[0]), 32'd1);
    endtask

    int rx[32], ry[32], ridx[32], rlast[32], rval[32];
    int e5x[5] = '{0, 4, 8, 12, 0};
    int e5y[5] = '{0, 0, 0, 0, 4};

    initial begin
        int vsum;
        rst = 1'b0; start = 1'b0; blk_ready = 1'b0;
        #2;
        check("rst_valid", 32'(valid_o[0]), 0);
        check("rst_busy", 32'(busy_o[0]), 0);
        check("rst_x", x_o[0], 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("idle_busy", 32'(busy_o[0]), 0);

        // Full frame with blk_ready held high.
        start = 1'b1; blk_ready = 1'b1;
        tick();
        start = 1'b0;
        check("latency_valid", 32'(valid_o[0]), 1);
        for (int i = 0; i < 32; i++) begin
            rx[i] = int'(x_o[0]); ry[i] = int'(y_o[0]);
            ridx[i] = int'(idx_o[0]); rlast[i] = int'(last_o[0]);
            rval[i] = int'(valid_o[0]);
            tick();
        end
        check("frame_done_pulse", 32'(fd_o[0]), 1);
        check("h32_valid", 32'(valid_o[1]), 1);
        check("h32_row2_x", x_o[1], 0);
        check("h32_row2_y", y_o[1], 16);
        check("h32_row2_idx", 32'(idx_o[1]), 0);
        vsum = 0;
        for (int i = 0; i < 32; i++) vsum += rval[i];
        check("consecutive_valid", 32'(vsum), 32);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("first_x%0d", i), 32'(rx[i]), 32'(e5x[i]));
            check($sformatf("first_y%0d", i), 32'(ry[i]), 32'(e5y[i]));
        end
        check("blk16_x", 32'(rx[16]), 16);
        check("blk16_y", 32'(ry[16]), 0);
        check("blk16_idx", 32'(ridx[16]), 0);
        check("last_x", 32'(rx[31]), 28);
        check("last_y", 32'(ry[31]), 12);
        check("last_mb_last", 32'(rlast[31]), 1);
        check("blk30_mb_last", 32'(rlast[30]), 0);

        // start held through DONE and the following idle cycle.
        start = 1'b1;
        tick();
        check("start_in_done_busy", 32'(busy_o[0]), 0);
        check("done_one_cycle", 32'(fd_o[0]), 0);
        tick();
        start = 1'b0;
        check("restart_valid", 32'(valid_o[0]), 1);
        check("restart_x", x_o[0], 0);
        check("restart_y", y_o[0], 0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_scan_x", x_o[0], 0);
        check("start_in_scan_y", y_o[0], 4);
        wait_done0();
        tick();

        // Back-pressure at (8,4).
        start = 1'b1; blk_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("stall_pre_x", x_o[0], 8);
        check("stall_pre_y", y_o[0], 4);
        blk_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_x", x_o[0], 8);
            check("stall_y", y_o[0], 4);
            check("stall_idx", 32'(idx_o[0]), 6);
        end
        blk_ready = 1'b1;
        tick();
        check("stall_post_x", x_o[0], 12);
        check("stall_post_y", y_o[0], 4);
        check("stall_post_idx", 32'(idx_o[0]), 7);
        wait_done0();
        tick();
        repeat (40) tick();

        // Asynchronous reset at block 10.
        start = 1'b1; blk_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("blk10_x", x_o[0], 8);
        check("blk10_y", y_o[0], 8);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(valid_o[0]), 0);
        check("arst_busy", 32'(busy_o[0]), 0);
        check("arst_x", x_o[0], 0);
        check("arst_y", y_o[0], 0);
        check("arst_idx", 32'(idx_o[0]), 0);
        check("arst_busy1", 32'(busy_o[1]), 0);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_busy", 32'(busy_o[0]), 0);
            check("post_rst_done", 32'(fd_o[0]), 0);
        end

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 4000; n++) begin
            blk_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                rst = 1'b1;
            end
            tick();
        end
        start = 1'b0; blk_ready = 1'b1;
        repeat (80) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
